prf_freelist_ctrl: RTL and testbench
====================================

Name: prf_freelist_ctrl

Overview:
- Dual-port physical-register free-list allocator for the rename (RNR) stage of the 2-wide out-of-order core.
- Hands out up to 2 free physical tags per cycle to renaming instructions with destinations, and reclaims up to 2 tags per cycle from commit.
- Keeps a committed head pointer so that `recover` restores the speculative head in one cycle, in lock-step with the speculative-table flush.
- Generates the allocation stall when too few tags remain.

Parameters:
- NPREG, 64, total physical registers.
- NARCH, 32, architectural registers; tags 0..NARCH-1 are never in the list at reset.
- DEPTH, NPREG-NARCH (32), free-list entries; must be a power of 2.
- TAG_W, 6, physical tag width (log2 NPREG).
- PTR_W, 5, log2 DEPTH; pointers carry one extra wrap bit (PTR_W+1 bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall_RNR  in  1  downstream stall; no allocation is consumed while high.
- recover  in  1  mispredict/exception flush; speculative allocations are discarded.
- rd1_en  in  1  rename slot 1 needs a destination tag.
- rd2_en  in  1  rename slot 2 needs a destination tag.
- rd1p  out  TAG_W  tag for slot 1 (combinational).
- rd2p  out  TAG_W  tag for slot 2 (combinational).
- alloc_stall  out  1  insufficient free tags for this cycle's request.
- com1_alloc  in  1  committing instruction 1 had allocated a tag.
- com2_alloc  in  1  committing instruction 2 had allocated a tag.
- free1_en  in  1  return free1_tag to the list.
- free1_tag  in  TAG_W  freed tag (old mapping of committing instruction 1).
- free2_en  in  1  return free2_tag to the list.
- free2_tag  in  TAG_W  freed tag of committing instruction 2.
- free_cnt  out  PTR_W+1  current speculative free count (tail - spec_head).
- ovf_err  out  1  sticky; a free was attempted with the list full.

Behaviour:
- State:
  - fifo[DEPTH] of TAG_W.
  - spec_head, com_head, tail: each PTR_W+1 bits.
  - ovf_err.
- Reset (async):
  - fifo[i] = NARCH+i.
  - spec_head = com_head = 0.
  - tail = DEPTH (wrap bit set, index 0).
  - free_cnt = 32, alloc_stall = 0, ovf_err = 0.
  - rd1p = 32, rd2p = 33 when enabled.
- Allocation (combinational read at spec_head):
  - need = rd1_en + rd2_en.
  - Both enabled: rd1p = fifo[spec_head], rd2p = fifo[spec_head+1].
  - Only rd2_en: rd2p = fifo[spec_head].
  - Only rd1_en: rd1p = fifo[spec_head].
  - Unrequested outputs drive 0.
- alloc_stall:
  - alloc_stall = (need > free_cnt), using registered pointers only.
  - Same-cycle frees do not bypass into the count, which avoids a comb path from commit.
- spec_head update at the clock edge:
  - recover=1: spec_head <= com_head_next (overrides everything).
  - Else if !stall_RNR && !alloc_stall: spec_head += need.
  - Else: hold.
- com_head update, every cycle regardless of stall/recover:
  - com_head_next = com_head + com1_alloc + com2_alloc.
- Free, every cycle regardless of stall/recover:
  - Both enabled: fifo[tail] = free1_tag, fifo[tail+1] = free2_tag, tail += 2.
  - One enabled: that tag is written at fifo[tail], tail += 1.
- Overflow: if (tail + nfree) - com_head > DEPTH, set ovf_err sticky and drop the excess writes.
- Pointer arithmetic: all pointer arithmetic is modulo 2^(PTR_W+1); fifo index = ptr[PTR_W-1:0].
- Full/empty:
  - free_cnt = 0 → alloc_stall whenever need ≥ 1.
  - free_cnt = 1 with need = 2 → stall, nothing consumed; no partial allocation.
- Recover in the same cycle as commit/free:
  - Frees and com_head advance normally.
  - spec_head takes com_head_next, so the freshly committed allocations stay consumed.
- Reset mid-operation: all state returns to reset values immediately; outputs are valid once rst deasserts.

Test Plan:
- Reset, then rd1_en=rd2_en=1 with no stall for 3 cycles → rd1p/rd2p = 32/33, 34/35, 36/37; free_cnt 32→30→28→26.
- Drain to free_cnt=1 (31 single allocs), then request need=2 → alloc_stall=1 and spec_head unchanged. Drop rd2_en → rd1p = 63, allocation proceeds, free_cnt=0.
- With free_cnt=0, free1_en=1 (tag 5) and free2_en=1 (tag 9) in one cycle → alloc_stall stays 1 that cycle. Next cycle free_cnt=2 and a dual alloc returns 5, 9.
- Allocate 6 tags, commit 2 with com1_alloc=com2_alloc=1, then assert recover → spec_head = com_head = 2, free_cnt = 30, next alloc returns 34.
- recover together with com1_alloc=1 in the same cycle, after 4 allocations with 0 committed → spec_head = 1 next cycle, next rd1p = 33.
- With the list full after reset (free_cnt=32), assert free1_en → ovf_err=1 and sticky, tail unchanged; assert rst mid-run → ovf_err=0, free_cnt=32.

Source files
------------

// File: rtl/prf_freelist_ctrl.sv
//------------------------------------------------------------------------------
// Module : prf_freelist_ctrl
// Brief  : Dual-port physical-register free list with speculative/committed heads.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prf_freelist_ctrl #(
  parameter int NPREG = 64,
  parameter int NARCH = 32,
  parameter int DEPTH = NPREG - NARCH,
  parameter int TAG_W = 6,
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_RNR,
  input  logic             recover,
  input  logic             rd1_en,
  input  logic             rd2_en,
  output logic [TAG_W-1:0] rd1p,
  output logic [TAG_W-1:0] rd2p,
  output logic             alloc_stall,
  input  logic             com1_alloc,
  input  logic             com2_alloc,
  input  logic             free1_en,
  input  logic [TAG_W-1:0] free1_tag,
  input  logic             free2_en,
  input  logic [TAG_W-1:0] free2_tag,
  output logic [PTR_W:0]   free_cnt,
  output logic             ovf_err
);

  localparam logic [PTR_W:0] c_ptr_one = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] c_depth   = (PTR_W+1)'(DEPTH);

  logic [TAG_W-1:0] fifo_q [DEPTH];
  logic [PTR_W:0]   spec_head_q, spec_head_d;
  logic [PTR_W:0]   com_head_q, com_head_d;
  logic [PTR_W:0]   tail_q, tail_d;
  logic             ovf_q, ovf_d;

  logic [PTR_W:0]   need;
  logic [PTR_W:0]   spec_head_p1;
  logic [PTR_W:0]   tail_p1;
  logic [PTR_W:0]   room;
  logic             wr0, wr1;
  logic [TAG_W-1:0] wr0_tag;

  assign need         = (PTR_W+1)'(rd1_en) + (PTR_W+1)'(rd2_en);
  assign spec_head_p1 = spec_head_q + c_ptr_one;
  assign tail_p1      = tail_q + c_ptr_one;

  // Stall depends only on registered pointers, so commit never feeds rename combinationally.
  assign free_cnt    = tail_q - spec_head_q;
  assign alloc_stall = (need > free_cnt);

  assign rd1p = rd1_en ? fifo_q[spec_head_q[PTR_W-1:0]] : '0;
  assign rd2p = !rd2_en ? '0 :
                rd1_en  ? fifo_q[spec_head_p1[PTR_W-1:0]] : fifo_q[spec_head_q[PTR_W-1:0]];

  // Slots between com_head and tail stay reserved: a recover may hand them out again.
  assign room    = c_depth - (tail_q - com_head_q);
  assign wr0     = (free1_en || free2_en) && (room != '0);
  assign wr1     = free1_en && free2_en && (room > c_ptr_one);
  assign wr0_tag = free1_en ? free1_tag : free2_tag;

  always_comb begin
    com_head_d = com_head_q + (PTR_W+1)'(com1_alloc) + (PTR_W+1)'(com2_alloc);
    tail_d     = tail_q + (PTR_W+1)'(wr0) + (PTR_W+1)'(wr1);
    ovf_d      = ovf_q
               || ((free1_en || free2_en) && !wr0)
               || (free1_en && free2_en && !wr1);
    if (recover) begin
      spec_head_d = com_head_d;
    end else if (!stall_RNR && !alloc_stall) begin
      spec_head_d = spec_head_q + need;
    end else begin
      spec_head_d = spec_head_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= TAG_W'(NARCH + i);
      end
      spec_head_q <= '0;
      com_head_q  <= '0;
      tail_q      <= c_depth;
      ovf_q       <= 1'b0;
    end else begin
      if (wr0) begin
        fifo_q[tail_q[PTR_W-1:0]] <= wr0_tag;
      end
      if (wr1) begin
        fifo_q[tail_p1[PTR_W-1:0]] <= free2_tag;
      end
      spec_head_q <= spec_head_d;
      com_head_q  <= com_head_d;
      tail_q      <= tail_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ovf_err = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_prf_freelist_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_prf_freelist_ctrl
// Brief  : Vector-table bench with expected-result queue for prf_freelist_ctrl.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_prf_freelist_ctrl;

  typedef struct {
    logic       rst, stall, rec, rd1, rd2, c1, c2, f1, f2;
    logic [5:0] f1t, f2t;
    logic [5:0] e1, e2;
    logic       es;
    logic [5:0] ecnt;
    logic       eovf;
  } vec_t;

  typedef struct {
    int         idx;
    logic [5:0] e1, e2;
    logic       es;
    logic [5:0] ecnt;
    logic       eovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall_RNR = 1'b0, recover = 1'b0, rd1_en = 1'b0, rd2_en = 1'b0;
  logic       com1_alloc = 1'b0, com2_alloc = 1'b0, free1_en = 1'b0, free2_en = 1'b0;
  logic [5:0] free1_tag = '0, free2_tag = '0;
  logic [5:0] rd1p, rd2p, free_cnt;
  logic       alloc_stall, ovf_err;

  int total = 0;
  int bad   = 0;

  vec_t tbl[$];
  exp_t sb[$];

  prf_freelist_ctrl dut (
    .clk(clk), .rst(rst), .stall_RNR(stall_RNR), .recover(recover),
    .rd1_en(rd1_en), .rd2_en(rd2_en), .rd1p(rd1p), .rd2p(rd2p),
    .alloc_stall(alloc_stall), .com1_alloc(com1_alloc), .com2_alloc(com2_alloc),
    .free1_en(free1_en), .free1_tag(free1_tag), .free2_en(free2_en),
    .free2_tag(free2_tag), .free_cnt(free_cnt), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // ctl string order: rst stall rec rd1 rd2 c1 c2 f1 f2
  function automatic vec_t mk(input bit [8:0] ctl, input int f1t, input int f2t,
                              input int e1, input int e2, input bit es,
                              input int ecnt, input bit eovf);
    vec_t v;
    v.rst = ctl[8]; v.stall = ctl[7]; v.rec = ctl[6]; v.rd1 = ctl[5]; v.rd2 = ctl[4];
    v.c1 = ctl[3]; v.c2 = ctl[2]; v.f1 = ctl[1]; v.f2 = ctl[0];
    v.f1t = 6'(f1t); v.f2t = 6'(f2t);
    v.e1 = 6'(e1); v.e2 = 6'(e2); v.es = es; v.ecnt = 6'(ecnt); v.eovf = eovf;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%0d required=%0d", nm, idx, act, exp);
    end
  endtask

  initial begin
    // Reset state and dual allocation
    tbl.push_back(mk(9'b1_0000_0000, 0, 0,  0,  0, 0, 32, 0));
    tbl.push_back(mk(9'b0_0000_0000, 0, 0,  0,  0, 0, 32, 0));
    tbl.push_back(mk(9'b0_0011_0000, 0, 0, 32, 33, 0, 32, 0));
    tbl.push_back(mk(9'b0_0011_0000, 0, 0, 34, 35, 0, 30, 0));
    tbl.push_back(mk(9'b0_0011_0000, 0, 0, 36, 37, 0, 28, 0));
    // Commit two, then recover to the committed head
    tbl.push_back(mk(9'b0_0000_1100, 0, 0,  0,  0, 0, 26, 0));
    tbl.push_back(mk(9'b0_0100_0000, 0, 0,  0,  0, 0, 26, 0));
    tbl.push_back(mk(9'b0_0010_0000, 0, 0, 34,  0, 0, 30, 0));
    tbl.push_back(mk(9'b0_0001_0000, 0, 0,  0, 35, 0, 29, 0));
    tbl.push_back(mk(9'b0_1011_0000, 0, 0, 36, 37, 0, 28, 0));
    tbl.push_back(mk(9'b0_0000_0000, 0, 0,  0,  0, 0, 28, 0));
    // Overflow on a full list, sticky until reset
    tbl.push_back(mk(9'b1_0000_0000, 0, 0,  0,  0, 0, 32, 0));
    tbl.push_back(mk(9'b0_0000_0010, 7, 0,  0,  0, 0, 32, 0));
    tbl.push_back(mk(9'b0_0000_0000, 0, 0,  0,  0, 0, 32, 1));
    tbl.push_back(mk(9'b0_0010_0000, 0, 0, 32,  0, 0, 32, 1));
    tbl.push_back(mk(9'b1_0000_0000, 0, 0,  0,  0, 0, 32, 0));
    // Recover in the same cycle as a commit
    tbl.push_back(mk(9'b0_0011_0000, 0, 0, 32, 33, 0, 32, 0));
    tbl.push_back(mk(9'b0_0011_0000, 0, 0, 34, 35, 0, 30, 0));
    tbl.push_back(mk(9'b0_0100_1000, 0, 0,  0,  0, 0, 28, 0));
    tbl.push_back(mk(9'b0_0010_0000, 0, 0, 33,  0, 0, 31, 0));
    // Drain to one entry, then empty-list behaviour and refill
    tbl.push_back(mk(9'b1_0000_0000, 0, 0,  0,  0, 0, 32, 0));
    for (int i = 0; i < 31; i++) begin
      tbl.push_back(mk(9'b0_0010_0000, 0, 0, 32 + i, 0, 0, 32 - i, 0));
    end
    tbl.push_back(mk(9'b0_0011_0000, 0, 0, 63, 32, 1, 1, 0));
    tbl.push_back(mk(9'b0_0010_0000, 0, 0, 63,  0, 0, 1, 0));
    tbl.push_back(mk(9'b0_0010_0000, 0, 0, 32,  0, 1, 0, 0));
    tbl.push_back(mk(9'b0_0000_1100, 0, 0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(9'b0_0010_0011, 5, 9, 32,  0, 1, 0, 0));
    tbl.push_back(mk(9'b0_0011_0000, 0, 0,  5,  9, 0, 2, 0));
    tbl.push_back(mk(9'b0_0000_0000, 0, 0,  0,  0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      exp_t g;
      @(negedge clk);
      rst        = tbl[i].rst;
      stall_RNR  = tbl[i].stall;
      recover    = tbl[i].rec;
      rd1_en     = tbl[i].rd1;
      rd2_en     = tbl[i].rd2;
      com1_alloc = tbl[i].c1;
      com2_alloc = tbl[i].c2;
      free1_en   = tbl[i].f1;
      free1_tag  = tbl[i].f1t;
      free2_en   = tbl[i].f2;
      free2_tag  = tbl[i].f2t;
      e.idx = i; e.e1 = tbl[i].e1; e.e2 = tbl[i].e2; e.es = tbl[i].es;
      e.ecnt = tbl[i].ecnt; e.eovf = tbl[i].eovf;
      sb.push_back(e);
      #1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", i);
      end else begin
        g = sb.pop_front();
        check("rd1p",        g.idx, int'(rd1p),        int'(g.e1));
        check("rd2p",        g.idx, int'(rd2p),        int'(g.e2));
        check("alloc_stall", g.idx, int'(alloc_stall), int'(g.es));
        check("free_cnt",    g.idx, int'(free_cnt),    int'(g.ecnt));
        check("ovf_err",     g.idx, int'(ovf_err),     int'(g.eovf));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
